// File: rtl/multi_tick_divider.sv
// Multi-channel tick/clock divider with runtime divisor reload applied at period boundaries.
// Optional single-step mode is compiled in with the DIVIDER_STEP_EN macro.
module multi_tick_divider #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 50000,
  localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_in,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                div_wr,
  input  logic [SEL_W-1:0]    div_sel,
  input  logic [WIDTH-1:0]    div_data,
`ifdef DIVIDER_STEP_EN
  input  logic                step_mode,
  input  logic                step_req,
`endif
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] clk_out
);

  localparam logic [WIDTH-1:0] DEF_DIV_C = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0]    cnt_r         [CHANNELS];
  logic [WIDTH-1:0]    active_div_r  [CHANNELS];
  logic [WIDTH-1:0]    pending_div_r [CHANNELS];
  logic [CHANNELS-1:0] pend_valid_r;
  logic [CHANNELS-1:0] tick_r;
  logic [CHANNELS-1:0] clk_out_r;

  logic [WIDTH-1:0]    cnt_nxt_s     [CHANNELS];
  logic [WIDTH-1:0]    active_nxt_s  [CHANNELS];
  logic [WIDTH-1:0]    pending_nxt_s [CHANNELS];
  logic [WIDTH-1:0]    load_div_s    [CHANNELS];
  logic [CHANNELS-1:0] pend_valid_nxt_s;
  logic [CHANNELS-1:0] tick_nxt_s;
  logic [CHANNELS-1:0] clk_out_nxt_s;
  logic [CHANNELS-1:0] wr_hit_s;
  logic [CHANNELS-1:0] wrap_s;
  logic [CHANNELS-1:0] fire_s;

  logic step_active_s;
  logic step_fire_s;
  logic step_exit_s;

`ifdef DIVIDER_STEP_EN
  logic [2:0] step_sync_r;
  logic       step_mode_r;

  // Synchronise the pushbutton and remember step_mode to spot the exit edge
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      step_sync_r <= 3'b000;
      step_mode_r <= 1'b0;
    end else begin
      step_sync_r <= {step_sync_r[1:0], step_req};
      step_mode_r <= step_mode;
    end
  end

  assign step_active_s = step_mode;
  assign step_fire_s   = step_sync_r[1] & ~step_sync_r[2];
  assign step_exit_s   = step_mode_r & ~step_mode;
`else
  assign step_active_s = 1'b0;
  assign step_fire_s   = 1'b0;
  assign step_exit_s   = 1'b0;
`endif

  // Per-channel decode: write hit, wrap detect and the divisor to load at a boundary
  always_comb begin
    wr_hit_s = '0;
    wrap_s   = '0;
    fire_s   = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      load_div_s[ch] = active_div_r[ch];
      wr_hit_s[ch]   = div_wr && (int'(div_sel) == ch);
      // cnt above active_div cannot happen normally; treat it as a wrap anyway
      wrap_s[ch]     = (cnt_r[ch] >= active_div_r[ch]);
      fire_s[ch]     = step_active_s ? step_fire_s : wrap_s[ch];
      if (wr_hit_s[ch]) begin
        load_div_s[ch] = div_data;
      end else if (pend_valid_r[ch]) begin
        load_div_s[ch] = pending_div_r[ch];
      end else begin
        load_div_s[ch] = active_div_r[ch];
      end
    end
  end

  // Next-state for counters, divisors and outputs
  always_comb begin
    cnt_nxt_s        = cnt_r;
    active_nxt_s     = active_div_r;
    pending_nxt_s    = pending_div_r;
    pend_valid_nxt_s = pend_valid_r;
    tick_nxt_s       = '0;
    clk_out_nxt_s    = clk_out_r;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      pending_nxt_s[ch] = wr_hit_s[ch] ? div_data : pending_div_r[ch];
      if (!en[ch]) begin
        cnt_nxt_s[ch]        = '0;
        clk_out_nxt_s[ch]    = 1'b0;
        active_nxt_s[ch]     = load_div_s[ch];
        pend_valid_nxt_s[ch] = 1'b0;
      end else if (fire_s[ch]) begin
        cnt_nxt_s[ch]        = '0;
        tick_nxt_s[ch]       = 1'b1;
        clk_out_nxt_s[ch]    = ~clk_out_r[ch];
        active_nxt_s[ch]     = load_div_s[ch];
        pend_valid_nxt_s[ch] = 1'b0;
      end else begin
        if (step_exit_s) begin
          cnt_nxt_s[ch] = '0;
        end else if (step_active_s) begin
          cnt_nxt_s[ch] = cnt_r[ch];
        end else begin
          cnt_nxt_s[ch] = cnt_r[ch] + WIDTH'(1);
        end
        pend_valid_nxt_s[ch] = pend_valid_r[ch] | wr_hit_s[ch];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        cnt_r[ch]         <= '0;
        active_div_r[ch]  <= DEF_DIV_C;
        pending_div_r[ch] <= DEF_DIV_C;
      end
      pend_valid_r <= '0;
      tick_r       <= '0;
      clk_out_r    <= '0;
    end else begin
      cnt_r         <= cnt_nxt_s;
      active_div_r  <= active_nxt_s;
      pending_div_r <= pending_nxt_s;
      pend_valid_r  <= pend_valid_nxt_s;
      tick_r        <= tick_nxt_s;
      clk_out_r     <= clk_out_nxt_s;
    end
  end

  assign tick    = tick_r;
  assign clk_out = clk_out_r;

endmodule
